// File: rtl/adder_pkg.sv
// adder_pkg: shared FSM state type and parameter check for the serial adder
package adder_pkg;
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} adder_state_t;
   function automatic bit is_pow_div(input int width, input int bpc);
      return width >= 2 && bpc > 0 && width % bpc == 0;
   endfunction
endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full adder cell used in the ripple chain
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);
   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle add/subtract, BITS_PER_CYCLE bits per clock with a registered carry
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH          = 8,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);
   localparam int K  = WIDTH / BITS_PER_CYCLE;
   localparam int CW = K > 1 ? $clog2(K) : 1;
   if (!is_pow_div(WIDTH, BITS_PER_CYCLE)) begin : g_bad_bpc
      $error("serial_adder: BITS_PER_CYCLE must divide WIDTH");
   end
   adder_state_t state, state_n;
   logic [CW-1:0] cnt;
   logic carry;
   logic [WIDTH-1:0] a_q, b_q;
   logic [BITS_PER_CYCLE-1:0] a_ch, b_ch, s_ch;
   logic [BITS_PER_CYCLE:0] c;
   logic last;
   int base;
   assign base = 32'(cnt) * BITS_PER_CYCLE;
   assign a_ch = a_q[base +: BITS_PER_CYCLE];
   assign b_ch = b_q[base +: BITS_PER_CYCLE];
   assign c[0] = carry;
   for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_fa
      full_adder u_fa (.a(a_ch[i]), .b(b_ch[i]), .cin(c[i]), .sum(s_ch[i]), .cout(c[i+1]));
   end
   assign last      = cnt == CW'(K - 1);
   assign in_ready  = state == ST_IDLE;
   assign out_valid = state == ST_DONE;
   always_comb begin
      state_n = state;
      if (state == ST_IDLE && in_valid) state_n = ST_RUN;
      else if (state == ST_RUN && last) state_n = ST_DONE;
      else if (state == ST_DONE && out_ready) state_n = ST_IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
         carry <= 1'b0;
         a_q   <= '0;
         b_q   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_n;
         if (state == ST_IDLE && in_valid) begin
            a_q   <= a;
            b_q   <= b ^ {WIDTH{sub}};
            carry <= sub;
            cnt   <= '0;
            sum   <= '0;
         end else if (state == ST_RUN) begin
            sum[base +: BITS_PER_CYCLE] <= s_ch;
            carry <= c[BITS_PER_CYCLE];
            cnt   <= cnt + CW'(1);
            // the MSB cell belongs to the final chunk, so its carry pair gives overflow
            if (last) begin
               cout <= c[BITS_PER_CYCLE];
               ovf  <= c[BITS_PER_CYCLE] ^ c[BITS_PER_CYCLE-1];
            end
         end
      end
   end
endmodule
